// File: rtl/br_perf_monitor.sv
//==============================================================================
// Module  : br_perf_monitor
// Brief   : Branch-prediction performance monitor with saturating counters,
//           sampling windows and longest-mispredict-run tracking.
// Revision: 1.0
//==============================================================================
`default_nettype none

module br_perf_monitor #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned WIN_W   = 16,
    parameter int unsigned WIN_LEN = 1024,
    parameter int unsigned RUN_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             instr_vld_i,
    input  logic             br_instr_i,
    input  logic             br_miss_i,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic [RUN_W-1:0] max_run_o,
    output logic [WIN_W-1:0] win_br_o,
    output logic [WIN_W-1:0] win_miss_o,
    output logic             win_vld_o,
    output logic             ovf_o,
    output logic [1:0]       state_o
);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_COUNT  = 2'b01;
    localparam logic [1:0] S_FROZEN = 2'b10;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_counting;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic [RUN_W-1:0] r_cur_run;
    logic [RUN_W-1:0] r_max_run;
    logic [RUN_W-1:0] w_run_nxt;
    logic             r_ovf;
    logic             w_ovf_set;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // stop outranks start, so start+stop in FROZEN or IDLE stays put
    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (!stop_i && start_i) w_state_nxt = S_COUNT;
                S_COUNT:  if (stop_i)             w_state_nxt = S_FROZEN;
                S_FROZEN: if (!stop_i && start_i) w_state_nxt = S_COUNT;
                default:                          w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_counting = (r_state == S_COUNT);
        state_o    = r_state;
    end

    assign w_ovf_set = w_counting & ((instr_vld_i & (&r_instr_cnt)) |
                                     (br_instr_i  & (&r_br_cnt))    |
                                     (br_miss_i   & (&r_miss_cnt)));

    always_comb begin
        w_run_nxt = r_cur_run;
        if (w_counting && br_instr_i) begin
            if (!br_miss_i)        w_run_nxt = '0;
            else if (!(&r_cur_run)) w_run_nxt = r_cur_run + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_instr_cnt <= '0;
            r_br_cnt    <= '0;
            r_miss_cnt  <= '0;
            r_cur_run   <= '0;
            r_max_run   <= '0;
            r_ovf       <= 1'b0;
        end else if (clear_i) begin
            r_instr_cnt <= '0;
            r_br_cnt    <= '0;
            r_miss_cnt  <= '0;
            r_cur_run   <= '0;
            r_max_run   <= '0;
            r_ovf       <= 1'b0;
        end else if (w_counting) begin
            if (instr_vld_i && !(&r_instr_cnt)) r_instr_cnt <= r_instr_cnt + 1'b1;
            if (br_instr_i  && !(&r_br_cnt))    r_br_cnt    <= r_br_cnt + 1'b1;
            if (br_miss_i   && !(&r_miss_cnt))  r_miss_cnt  <= r_miss_cnt + 1'b1;
            r_cur_run <= w_run_nxt;
            if (w_run_nxt > r_max_run) r_max_run <= w_run_nxt;
            if (w_ovf_set) r_ovf <= 1'b1;
        end
    end

    assign instr_cnt_o = r_instr_cnt;
    assign br_cnt_o    = r_br_cnt;
    assign miss_cnt_o  = r_miss_cnt;
    assign max_run_o   = r_max_run;
    assign ovf_o       = r_ovf;

    generate
        if (WIN_LEN != 0) begin : g_win
            localparam logic [WIN_W-1:0] c_win_last = WIN_W'(WIN_LEN - 1);

            logic [WIN_W-1:0] r_win_icnt;
            logic [WIN_W-1:0] r_win_br;
            logic [WIN_W-1:0] r_win_miss;
            logic [WIN_W-1:0] r_win_br_out;
            logic [WIN_W-1:0] r_win_miss_out;
            logic             r_win_vld;
            logic [WIN_W-1:0] w_win_br_nxt;
            logic [WIN_W-1:0] w_win_miss_nxt;
            logic             w_win_end;

            // window counts including this cycle's events, saturating
            assign w_win_br_nxt   = (br_instr_i && !(&r_win_br))  ? r_win_br + 1'b1   : r_win_br;
            assign w_win_miss_nxt = (br_miss_i  && !(&r_win_miss)) ? r_win_miss + 1'b1 : r_win_miss;
            assign w_win_end      = w_counting & instr_vld_i & (r_win_icnt == c_win_last);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_win_icnt     <= '0;
                    r_win_br       <= '0;
                    r_win_miss     <= '0;
                    r_win_br_out   <= '0;
                    r_win_miss_out <= '0;
                    r_win_vld      <= 1'b0;
                end else if (clear_i) begin
                    r_win_icnt     <= '0;
                    r_win_br       <= '0;
                    r_win_miss     <= '0;
                    r_win_br_out   <= '0;
                    r_win_miss_out <= '0;
                    r_win_vld      <= 1'b0;
                end else begin
                    r_win_vld <= w_win_end;
                    if (w_win_end) begin
                        r_win_br_out   <= w_win_br_nxt;
                        r_win_miss_out <= w_win_miss_nxt;
                        r_win_icnt     <= '0;
                        r_win_br       <= '0;
                        r_win_miss     <= '0;
                    end else if (w_counting) begin
                        if (instr_vld_i && !(&r_win_icnt)) r_win_icnt <= r_win_icnt + 1'b1;
                        r_win_br   <= w_win_br_nxt;
                        r_win_miss <= w_win_miss_nxt;
                    end
                end
            end

            assign win_br_o   = r_win_br_out;
            assign win_miss_o = r_win_miss_out;
            assign win_vld_o  = r_win_vld;
        end else begin : g_no_win
            assign win_br_o   = '0;
            assign win_miss_o = '0;
            assign win_vld_o  = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_br_perf_monitor.sv
//==============================================================================
// Module  : tb_br_perf_monitor
// Brief   : Directed vector bench for br_perf_monitor (CNT_W=4, WIN_LEN=4).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_br_perf_monitor;

    localparam int CNT_W   = 4;
    localparam int WIN_W   = 8;
    localparam int WIN_LEN = 4;
    localparam int RUN_W   = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             clear_i = 1'b0;
    logic             start_i = 1'b0;
    logic             stop_i = 1'b0;
    logic             instr_vld_i = 1'b0;
    logic             br_instr_i = 1'b0;
    logic             br_miss_i = 1'b0;
    logic [CNT_W-1:0] instr_cnt_o;
    logic [CNT_W-1:0] br_cnt_o;
    logic [CNT_W-1:0] miss_cnt_o;
    logic [RUN_W-1:0] max_run_o;
    logic [WIN_W-1:0] win_br_o;
    logic [WIN_W-1:0] win_miss_o;
    logic             win_vld_o;
    logic             ovf_o;
    logic [1:0]       state_o;

    int checks = 0;
    int failures = 0;

    br_perf_monitor #(
        .CNT_W(CNT_W), .WIN_W(WIN_W), .WIN_LEN(WIN_LEN), .RUN_W(RUN_W)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .stop_i(stop_i), .instr_vld_i(instr_vld_i), .br_instr_i(br_instr_i),
        .br_miss_i(br_miss_i), .instr_cnt_o(instr_cnt_o), .br_cnt_o(br_cnt_o),
        .miss_cnt_o(miss_cnt_o), .max_run_o(max_run_o), .win_br_o(win_br_o),
        .win_miss_o(win_miss_o), .win_vld_o(win_vld_o), .ovf_o(ovf_o),
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit st, sp, cl, v, b, m;
        int e_instr, e_br, e_miss, e_max, e_wbr, e_wmiss, e_wvld, e_ovf, e_state;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input int ei, input int eb, input int em,
                           input int emax, input int ewb, input int ewm, input int ewv,
                           input int eo, input int es);
        chk("instr_cnt", idx, int'(instr_cnt_o), ei);
        chk("br_cnt",    idx, int'(br_cnt_o),    eb);
        chk("miss_cnt",  idx, int'(miss_cnt_o),  em);
        chk("max_run",   idx, int'(max_run_o),   emax);
        chk("win_br",    idx, int'(win_br_o),    ewb);
        chk("win_miss",  idx, int'(win_miss_o),  ewm);
        chk("win_vld",   idx, int'(win_vld_o),   ewv);
        chk("ovf",       idx, int'(ovf_o),       eo);
        chk("state",     idx, int'(state_o),     es);
    endtask

    task automatic drive(input bit st, input bit sp, input bit cl,
                         input bit v, input bit b, input bit m);
        start_i = st; stop_i = sp; clear_i = cl;
        instr_vld_i = v; br_instr_i = b; br_miss_i = m;
    endtask

    task automatic step(input bit st, input bit sp, input bit cl,
                        input bit v, input bit b, input bit m);
        drive(st, sp, cl, v, b, m);
        @(posedge clk_i);
        #1;
    endtask

    task automatic add(input bit st, input bit sp, input bit cl, input bit v,
                       input bit b, input bit m, input int ei, input int eb,
                       input int em, input int emax, input int ewb, input int ewm,
                       input int ewv, input int eo, input int es);
        vec_t t;
        t.st = st; t.sp = sp; t.cl = cl; t.v = v; t.b = b; t.m = m;
        t.e_instr = ei; t.e_br = eb; t.e_miss = em; t.e_max = emax;
        t.e_wbr = ewb; t.e_wmiss = ewm; t.e_wvld = ewv; t.e_ovf = eo; t.e_state = es;
        vecs.push_back(t);
    endtask

    initial begin
        // st sp cl v b m | instr br miss max wbr wmiss wvld ovf state
        add(1,0,0, 0,0,0,   0,0,0, 0, 0,0,0, 0,1);   // 0 start, not counted
        add(0,0,0, 1,1,0,   1,1,0, 0, 0,0,0, 0,1);
        add(0,0,0, 1,1,1,   2,2,1, 1, 0,0,0, 0,1);
        add(0,0,0, 1,0,0,   3,2,1, 1, 0,0,0, 0,1);
        add(0,0,0, 1,0,0,   4,2,1, 1, 2,1,1, 0,1);   // 4 first window closes
        add(0,0,0, 1,1,0,   5,3,1, 1, 2,1,0, 0,1);
        add(0,0,0, 1,0,0,   6,3,1, 1, 2,1,0, 0,1);
        add(0,0,0, 1,0,0,   7,3,1, 1, 2,1,0, 0,1);
        add(0,0,0, 1,0,0,   8,3,1, 1, 1,0,1, 0,1);   // 8 second window
        add(0,0,0, 1,0,0,   9,3,1, 1, 1,0,0, 0,1);
        add(0,0,0, 1,0,0,  10,3,1, 1, 1,0,0, 0,1);   // 10 test-plan totals
        add(0,1,0, 0,0,0,  10,3,1, 1, 1,0,0, 0,2);   // stop -> FROZEN
        add(0,0,0, 1,1,1,  10,3,1, 1, 1,0,0, 0,2);   // ignored while frozen
        add(1,0,0, 1,0,0,  10,3,1, 1, 1,0,0, 0,1);   // resume, start cycle not counted
        add(0,0,0, 1,0,0,  11,3,1, 1, 1,0,0, 0,1);
        add(0,0,0, 1,0,0,  12,3,1, 1, 0,0,1, 0,1);   // window spans stop/start
        add(0,0,0, 1,0,0,  13,3,1, 1, 0,0,0, 0,1);
        add(0,0,0, 1,0,0,  14,3,1, 1, 0,0,0, 0,1);
        add(0,0,0, 1,0,0,  15,3,1, 1, 0,0,0, 0,1);
        add(0,0,0, 1,0,0,  15,3,1, 1, 0,0,1, 1,1);   // 16th instr saturates
        add(0,0,0, 1,0,0,  15,3,1, 1, 0,0,0, 1,1);
        add(0,0,1, 1,1,1,   0,0,0, 0, 0,0,0, 0,0);   // clear wins, events dropped
        add(1,0,0, 0,0,0,   0,0,0, 0, 0,0,0, 0,1);
        add(0,0,0, 1,1,1,   1,1,1, 1, 0,0,0, 0,1);
        add(1,1,1, 1,0,0,   0,0,0, 0, 0,0,0, 0,0);   // all three controls
        add(1,0,0, 0,0,0,   0,0,0, 0, 0,0,0, 0,1);
        add(0,0,0, 0,1,1,   0,1,1, 1, 0,0,0, 0,1);   // miss
        add(0,0,0, 0,1,1,   0,2,2, 2, 0,0,0, 0,1);   // miss
        add(0,0,0, 0,0,0,   0,2,2, 2, 0,0,0, 0,1);   // non-branch gap
        add(0,0,0, 0,1,1,   0,3,3, 3, 0,0,0, 0,1);   // miss, run 3
        add(0,0,0, 0,1,0,   0,4,3, 3, 0,0,0, 0,1);   // hit breaks run
        add(0,0,0, 0,1,1,   0,5,4, 3, 0,0,0, 0,1);
        add(0,0,0, 0,0,1,   0,5,5, 3, 0,0,0, 0,1);   // miss without branch
        add(0,0,0, 0,1,1,   0,6,6, 3, 0,0,0, 0,1);   // cur_run = 2
        add(0,0,0, 0,1,1,   0,7,7, 3, 0,0,0, 0,1);   // cur_run = 3
        add(0,0,0, 0,1,1,   0,8,8, 4, 0,0,0, 0,1);   // cur_run = 4 beats max
        add(1,1,0, 0,0,0,   0,8,8, 4, 0,0,0, 0,2);   // stop beats start
        add(1,1,0, 0,0,0,   0,8,8, 4, 0,0,0, 0,2);   // stays frozen
        add(0,0,1, 0,0,0,   0,0,0, 0, 0,0,0, 0,0);
        add(0,0,0, 1,1,1,   0,0,0, 0, 0,0,0, 0,0);   // IDLE ignores events

        // reset state
        #3;
        chk_all(-1, 0,0,0, 0, 0,0,0, 0,0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk_all(-2, 0,0,0, 0, 0,0,0, 0,0);

        foreach (vecs[i]) begin
            step(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].v, vecs[i].b, vecs[i].m);
            chk_all(i, vecs[i].e_instr, vecs[i].e_br, vecs[i].e_miss, vecs[i].e_max,
                    vecs[i].e_wbr, vecs[i].e_wmiss, vecs[i].e_wvld, vecs[i].e_ovf,
                    vecs[i].e_state);
        end

        // async reset mid-window with win_icnt=2
        step(1,0,0, 0,0,0);
        step(0,0,0, 1,1,1);
        step(0,0,0, 1,1,0);
        chk("pre_reset_instr", 100, int'(instr_cnt_o), 2);
        drive(0,0,0, 0,0,0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all(101, 0,0,0, 0, 0,0,0, 0,0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post_reset_state", 102, int'(state_o), 0);

        // partial window discarded: first window closes on the 4th new instr
        step(1,0,0, 0,0,0);
        step(0,0,0, 1,1,0);
        step(0,0,0, 1,0,0);
        step(0,0,0, 1,0,0);
        chk("win_vld_after_3", 103, int'(win_vld_o), 0);
        step(0,0,0, 1,0,0);
        chk("win_vld_after_4", 104, int'(win_vld_o), 1);
        chk("win_br_after_4",  105, int'(win_br_o),  1);
        step(0,0,0, 0,0,0);
        chk("win_vld_one_cycle", 106, int'(win_vld_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/br_perf_monitor.md
Name: br_perf_monitor

Overview:
- Parametrised branch-prediction performance monitor; successor to the per-predictor event taps in the simulation top.
- Counts valid instructions, branch/jump instructions and mispredict flushes for one predictor core.
- Adds start/stop/clear control, saturating counters, a sticky overflow flag, fixed-length sampling windows, and tracking of the longest run of consecutive mispredicted branches.
- Instantiated in the simulation top (or FPGA debug wrapper), fed from the core's EXMEM_is_jmp, IF_flush and instruction-valid signals.

Parameters:
- CNT_W, 32, width of the cumulative counters.
- WIN_W, 16, width of the window length and window counters.
- WIN_LEN, 1024, instructions per sampling window; 0 disables windowing.
- RUN_W, 8, width of the mispredict-run counters.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear of all counters and flags.
- start_i  in  1  begin or resume counting.
- stop_i  in  1  freeze counting.
- instr_vld_i  in  1  one retired/valid instruction this cycle.
- br_instr_i  in  1  branch/jump resolved this cycle.
- br_miss_i  in  1  mispredict flush this cycle.
- instr_cnt_o  out  CNT_W  cumulative valid instructions.
- br_cnt_o  out  CNT_W  cumulative branches.
- miss_cnt_o  out  CNT_W  cumulative mispredicts.
- max_run_o  out  RUN_W  longest consecutive mispredicted-branch run.
- win_br_o  out  WIN_W  branches in the last completed window.
- win_miss_o  out  WIN_W  mispredicts in the last completed window.
- win_vld_o  out  1  one-cycle pulse when the window registers update.
- ovf_o  out  1  sticky: any counter saturated.
- state_o  out  2  00 IDLE, 01 COUNT, 10 FROZEN.

Behaviour:
- Reset (async, rst_ni=0): all outputs 0; state IDLE; internal window and run counters 0.
- FSM (registered):
  - IDLE --start_i--> COUNT.
  - COUNT --stop_i--> FROZEN.
  - FROZEN --start_i--> COUNT (resume; counts kept).
  - Any state --clear_i--> IDLE.
  - Priority when asserted together: clear_i > stop_i > start_i.
- Events are sampled only while the current (registered) state is COUNT. The cycle in which start_i is seen is not counted; the cycle in which stop_i is seen is counted.
- Counter update latency: 1 cycle, registered.
  - instr_cnt += instr_vld_i
  - br_cnt += br_instr_i
  - miss_cnt += br_miss_i
  - br_miss_i is counted even when br_instr_i=0.
- Saturation: each cumulative counter holds at all-ones. ovf_o sets on the cycle an increment is blocked and stays set until clear_i or reset. The window and run counters saturate the same way but do not set ovf_o.
- Mispredict run:
  - Cycle with br_instr_i=1 and br_miss_i=1: cur_run += 1.
  - Cycle with br_instr_i=1 and br_miss_i=0: cur_run := 0.
  - Cycles with br_instr_i=0 leave cur_run unchanged.
  - max_run_o := max(max_run_o, next cur_run), updated in the same cycle as cur_run.
- Window (only when WIN_LEN != 0):
  - win_icnt counts instr_vld_i in COUNT.
  - In the cycle where instr_vld_i=1 and win_icnt == WIN_LEN-1:
    - win_br_o/win_miss_o load the window counts including this cycle's events.
    - Window counters reset to 0.
    - win_vld_o=1 on the next cycle, for exactly one cycle.
  - Otherwise win_vld_o=0.
  - Window counters hold while FROZEN; a window may span a stop/start.
- clear_i: next cycle all counters, max_run_o, window registers, ovf_o and the partial window are 0; state IDLE. Events in the clear cycle are discarded.
- Reset asserted mid-window discards everything immediately (asynchronous).

Test Plan:
- Reset, then start_i pulse, then 10 cycles with instr_vld_i=1, 3 with br_instr_i=1, 1 with br_miss_i=1 -> instr_cnt_o=10, br_cnt_o=3, miss_cnt_o=1, state_o=01.
- WIN_LEN=4: start, 9 valid instructions, 2 branches within the first 4 (one of them a miss) -> win_vld_o pulses after the 4th and 8th instructions; first window win_br_o=2, win_miss_o=1; 9th instruction held in the partial window.
- Branch pattern miss, miss, miss, hit, miss, miss -> max_run_o=3 at end; cur_run=2; a non-branch cycle between misses does not break the run.
- CNT_W=4: 17 valid instructions -> instr_cnt_o=15, ovf_o=1 from the 16th instruction onward; clear_i -> all 0, ovf_o=0, state_o=00.
- start_i, stop_i and clear_i in the same cycle while in COUNT -> state IDLE, counters 0. stop_i alone in COUNT -> FROZEN; instructions while FROZEN are not counted; start_i resumes from the held values.
- Assert rst_ni=0 mid-window (win_icnt=2) asynchronously -> all outputs 0 immediately; after release, state_o=00.
